// File: rtl/dm_pkg.sv
// Shared constants for the latency-modelled data memory.
// FSM encoding, default sizes and a clog2 helper.
package dm_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t WAIT = 2'd1;
  localparam state_t ACK  = 2'd2;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DEPTH      = 256;
  localparam int DEF_LATENCY    = 10;
  localparam int CNT_WIDTH      = 8;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/data_memory_latency_if.sv
// Request/acknowledge bus between a requester
// and the latency-modelled data memory.
interface data_memory_latency_if #(
  parameter int DATA_WIDTH = dm_pkg::DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = dm_pkg::DEF_ADDR_WIDTH
);

  logic                    req_i;
  logic                    write_i;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic [DATA_WIDTH/8-1:0] be_i;
  logic [DATA_WIDTH-1:0]   write_data_i;
  logic                    ack_o;
  logic                    busy_o;
  logic [DATA_WIDTH-1:0]   read_data_o;
  logic                    err_o;

  modport master (
    output req_i,
    output write_i,
    output addr_i,
    output be_i,
    output write_data_i,
    input  ack_o,
    input  busy_o,
    input  read_data_o,
    input  err_o
  );

  modport slave (
    input  req_i,
    input  write_i,
    input  addr_i,
    input  be_i,
    input  write_data_i,
    output ack_o,
    output busy_o,
    output read_data_o,
    output err_o
  );

endinterface

// File: rtl/dm_latency_counter.sv
// Loadable down-counter that stops at zero;
// times the access latency of the data memory.
module dm_latency_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/data_memory_latency.sv
// Word RAM behind a req/ack handshake with a fixed
// access latency, byte-enable writes and range check.
module data_memory_latency
  import dm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LATENCY    = DEF_LATENCY
) (
  input logic clk_i,
  input logic rst_i,
  data_memory_latency_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam int BW = DATA_WIDTH / 8;
  localparam logic [CNT_WIDTH-1:0] LOAD_VAL =
    CNT_WIDTH'(LATENCY - 1);

  logic [DATA_WIDTH-1:0] memory [DEPTH];

  state_t                state;
  logic                  wr_q;
  logic [AW-1:0]         idx_q;
  logic                  oor_q;
  logic [BW-1:0]         be_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rd_q;

  logic                  accept;
  logic                  access;
  logic                  zero;
  logic                  oor;

  // Any address bit above the word index is out of range
  assign oor    = (bus.addr_i >> (AW + 2)) != '0;
  assign accept = (state == IDLE) && bus.req_i;
  assign access = (state == WAIT) && zero;

  dm_latency_counter #(
    .W(CNT_WIDTH)
  ) u_cnt (
    .clk_i    (clk_i),
    .rst_n    (rst_i),
    .load     (accept),
    .en       (state == WAIT),
    .load_val (LOAD_VAL),
    .zero     (zero)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      wr_q  <= 1'b0;
      idx_q <= '0;
      oor_q <= 1'b0;
      be_q  <= '0;
      wd_q  <= '0;
      err_q <= 1'b0;
      rd_q  <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.req_i) begin
            wr_q  <= bus.write_i;
            idx_q <= bus.addr_i[AW+1:2];
            oor_q <= oor;
            be_q  <= bus.be_i;
            wd_q  <= bus.write_data_i;
            state <= WAIT;
          end
        end
        (state == WAIT): begin
          if (zero) begin
            err_q <= oor_q;
            if (!wr_q) begin
              rd_q <= oor_q ? '0 : memory[idx_q];
            end
            state <= ACK;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Reset forces IDLE asynchronously, so an
  // abandoned write never reaches the array.
  always_ff @(posedge clk_i) begin
    if (access && wr_q && !oor_q) begin
      for (int i = 0; i < BW; i++) begin
        if (be_q[i]) begin
          memory[idx_q][8*i +: 8] <= wd_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.ack_o       = (state == ACK);
  assign bus.busy_o      = (state != IDLE);
  assign bus.err_o       = (state == ACK) && err_q;
  assign bus.read_data_o = rd_q;

endmodule

// File: tb/tb_data_memory_latency.sv
// Directed bench for data_memory_latency with a
// LATENCY=10 and a LATENCY=1 instance.
module tb_data_memory_latency;

  logic clk;
  logic rst_i;

  data_memory_latency_if #(32, 32) bus10 ();
  data_memory_latency_if #(32, 32) bus1 ();

  data_memory_latency #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEPTH(256),
    .LATENCY(10)
  ) dut10 (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus10.slave)
  );

  data_memory_latency #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEPTH(256),
    .LATENCY(1)
  ) dut1 (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel,
                       input logic req,
                       input logic w,
                       input logic [31:0] a,
                       input logic [3:0] b,
                       input logic [31:0] d);
    if (sel) begin
      bus1.req_i        = req;
      bus1.write_i      = w;
      bus1.addr_i       = a;
      bus1.be_i         = b;
      bus1.write_data_i = d;
    end else begin
      bus10.req_i        = req;
      bus10.write_i      = w;
      bus10.addr_i       = a;
      bus10.be_i         = b;
      bus10.write_data_i = d;
    end
  endtask

  // One transaction; inputs are scrambled after
  // acceptance so only latched copies can matter.
  task automatic run(input bit sel,
                     input logic w,
                     input logic [31:0] a,
                     input logic [3:0] b,
                     input logic [31:0] d,
                     output int lat,
                     output logic err,
                     output logic [31:0] rd);
    logic ack;
    @(negedge clk);
    drive(sel, 1'b1, w, a, b, d);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, ~w, 32'h0000_000C, ~b, ~d);
    lat = -1;
    err = 1'bx;
    rd  = 'x;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      ack = sel ? bus1.ack_o : bus10.ack_o;
      if (ack) begin
        lat = k;
        err = sel ? bus1.err_o : bus10.err_o;
        rd  = sel ? bus1.read_data_o
                  : bus10.read_data_o;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int          lat;
  logic        err;
  logic [31:0] rd;
  int          acks;
  int          a1;
  int          a2;
  int          idle;
  bit          done;

  initial begin
    tests = 0;
    fails = 0;
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_ack", 32'(bus10.ack_o), 32'd0);
    chk("rst_busy", 32'(bus10.busy_o), 32'd0);
    chk("rst_err", 32'(bus10.err_o), 32'd0);
    chk("rst_rd", bus10.read_data_o, 32'h0);

    run(1'b0, 1'b1, 32'h0, 4'hF, 32'h1,
        lat, err, rd);
    chk("wr0_lat", 32'(lat), 32'd10);
    chk("wr0_err", 32'(err), 32'd0);
    chk("wr0_mem", dut10.memory[0], 32'h1);
    chk("wr0_rdhold", rd, 32'h0);

    run(1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
        lat, err, rd);
    chk("rd0_lat", 32'(lat), 32'd10);
    chk("rd0_data", rd, 32'h1);
    chk("rd0_err", 32'(err), 32'd0);

    run(1'b0, 1'b0, 32'h1, 4'h0, 32'h0,
        lat, err, rd);
    chk("rd1_data", rd, 32'h1);

    run(1'b0, 1'b1, 32'h8, 4'hF, 32'hAABB_CCDD,
        lat, err, rd);
    chk("pre2_mem", dut10.memory[2], 32'hAABB_CCDD);
    run(1'b0, 1'b1, 32'h8, 4'b0101, 32'h1122_3344,
        lat, err, rd);
    chk("be_mem", dut10.memory[2], 32'hAA22_CC44);
    run(1'b0, 1'b0, 32'h8, 4'h0, 32'h0,
        lat, err, rd);
    chk("be_rd", rd, 32'hAA22_CC44);

    run(1'b0, 1'b0, 32'h400, 4'h0, 32'h0,
        lat, err, rd);
    chk("oor_rd_lat", 32'(lat), 32'd10);
    chk("oor_rd_err", 32'(err), 32'd1);
    chk("oor_rd_data", rd, 32'h0);

    run(1'b0, 1'b1, 32'h400, 4'hF, 32'hFFFF_FFFF,
        lat, err, rd);
    chk("oor_wr_err", 32'(err), 32'd1);
    chk("oor_wr_mem0", dut10.memory[0], 32'h1);
    chk("oor_wr_rdhold", rd, 32'h0);

    // Second request mid-read must be ignored
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    bus10.req_i = 1'b0;
    acks = 0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      #1;
      if (bus10.ack_o) acks++;
      if (k == 3) bus10.req_i = 1'b1;
      if (k == 4) bus10.req_i = 1'b0;
    end
    chk("busy_one_ack", 32'(acks), 32'd1);

    // Held request: back-to-back transactions
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    a1 = 0;
    a2 = 0;
    idle = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus10.ack_o) begin
        if (a1 == 0) a1 = k;
        else if (a2 == 0) a2 = k;
      end
      if (a1 != 0 && a2 == 0 && !bus10.busy_o)
        idle++;
    end
    bus10.req_i = 1'b0;
    chk("b2b_first", 32'(a1), 32'd11);
    chk("b2b_gap", 32'(a2 - a1), 32'd12);
    chk("b2b_idle", 32'(idle), 32'd1);
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk);
      #1;
      if (!bus10.busy_o) done = 1'b1;
    end
    chk("b2b_drain", 32'(done), 32'd1);

    run(1'b0, 1'b1, 32'h4, 4'hF, 32'h1234_5678,
        lat, err, rd);
    chk("pre1_mem", dut10.memory[1], 32'h1234_5678);

    // Reset during an outstanding write
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h4, 4'hF,
          32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    bus10.req_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_i = 1'b0;
    #1;
    chk("rstmid_busy", 32'(bus10.busy_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    acks = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (bus10.ack_o) acks++;
    end
    chk("rstmid_noack", 32'(acks), 32'd0);
    chk("rstmid_mem1", dut10.memory[1], 32'h1234_5678);

    run(1'b1, 1'b1, 32'h10, 4'hF, 32'h55,
        lat, err, rd);
    chk("l1_wr_lat", 32'(lat), 32'd1);
    run(1'b1, 1'b0, 32'h10, 4'h0, 32'h0,
        lat, err, rd);
    chk("l1_rd_lat", 32'(lat), 32'd1);
    chk("l1_rd_data", rd, 32'h55);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
